sparse_rot_mult_core: RTL and testbench



---
 rtl/sparse_rot_mult_core_pkg.sv | 24 ++
 rtl/sparse_rot_mult_core_if.sv | 26 ++
 rtl/sparse_rot_mult_core_cyclic_rotator.sv | 22 ++
 rtl/sparse_rot_mult_core.sv | 126 ++++++++++++
 tb/tb_sparse_rot_mult_core.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_rot_mult_core_pkg.sv
// Shared definitions for the sparse rotate-multiply core: FSM states, parameter
// defaults and the layout of one key slot.
package sparse_rot_mult_core_pkg;

  localparam int unsigned DefN        = 128;
  localparam int unsigned DefIdxW     = 7;
  localparam int unsigned DefW        = 16;
  localparam int unsigned DefKeyWidth = 128;

  // Slot layout: {valid, position[IdxW-1:0]}.
  localparam int unsigned SlotW        = DefIdxW + 1;
  localparam int unsigned SlotValidBit = DefIdxW;
  localparam int unsigned SlotPosLsb   = 0;
  localparam int unsigned SlotPosMsb   = DefIdxW - 1;
  localparam int unsigned CntW         = $clog2(DefW);

  typedef enum logic {StIdle, StAcc} state_e;

  // Slot counter width for an arbitrary slot count (at least one bit).
  function automatic int unsigned cnt_width(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sparse_rot_mult_core_if.sv
// Start/busy/done block interface between the register block (master) and the
// multiply core (slave).
interface sparse_rot_mult_core_if #(
  parameter int unsigned pN         = 128,
  parameter int unsigned pKEY_WIDTH = 128
);

  logic                  load_i;
  logic [pKEY_WIDTH-1:0] key_i;
  logic [pN-1:0]         data_i;
  logic [pN-1:0]         data_o;
  logic                  ready_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output load_i, key_i, data_i,
    input  data_o, ready_o, busy_o, done_o
  );

  modport slave (
    input  load_i, key_i, data_i,
    output data_o, ready_o, busy_o, done_o
  );

endinterface

// File: rtl/sparse_rot_mult_core_cyclic_rotator.sv
// Combinational cyclic left rotator: bit i of the result is data_i[(i - shift_i) mod pN].
module cyclic_rotator #(
  parameter int unsigned pN     = 128,
  parameter int unsigned pIDX_W = 7
) (
  input  logic [pN-1:0]     data_i,
  input  logic [pIDX_W-1:0] shift_i,
  output logic [pN-1:0]     data_o
);

  logic [pN-1:0] stage [pIDX_W+1];

  assign stage[0] = data_i;

  for (genvar s = 0; s < pIDX_W; s++) begin : g_stage
    localparam int unsigned Sh = 1 << s;
    assign stage[s+1] = shift_i[s] ? ((stage[s] << Sh) | (stage[s] >> (pN - Sh))) : stage[s];
  end

  assign data_o = stage[pIDX_W];

endmodule

// File: rtl/sparse_rot_mult_core.sv
// Constant-time sparse x dense product in GF(2)[x]/(x^pN - 1); one key slot per
// cycle, invalid slots fold into a dummy accumulator so every slot costs the same.
module sparse_rot_mult_core
  import sparse_rot_mult_core_pkg::*;
#(
  parameter int unsigned pN         = DefN,
  parameter int unsigned pIDX_W     = DefIdxW,
  parameter int unsigned pW         = DefW,
  parameter int unsigned pKEY_WIDTH = DefKeyWidth
) (
  input  logic                   clk,
  input  logic                   resetn,
  sparse_rot_mult_core_if.slave  bus
);

  localparam int unsigned SlotWidth = pIDX_W + 1;
  localparam int unsigned CntWidth  = cnt_width(pW);

  state_e                state_q, state_d;
  logic [pN-1:0]         op_q, op_d;
  logic [pKEY_WIDTH-1:0] key_q, key_d;
  logic [pN-1:0]         acc_q, acc_d;
  logic [pN-1:0]         dummy_q, dummy_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [pN-1:0]         data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic [SlotWidth-1:0]  slots [pW];
  logic [SlotWidth-1:0]  slot_cur;
  logic                  slot_valid;
  logic [pIDX_W-1:0]     slot_pos;
  logic [pN-1:0]         rot;

  for (genvar k = 0; k < pW; k++) begin : g_slot
    assign slots[k] = key_q[k*SlotWidth +: SlotWidth];
  end

  assign slot_cur   = slots[cnt_q];
  assign slot_valid = slot_cur[pIDX_W];
  assign slot_pos   = slot_cur[pIDX_W-1:0];

  cyclic_rotator #(
    .pN     (pN),
    .pIDX_W (pIDX_W)
  ) u_rot (
    .data_i  (op_q),
    .shift_i (slot_pos),
    .data_o  (rot)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    acc_d   = acc_q;
    dummy_d = dummy_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load_i) begin
          state_d = StAcc;
          op_d    = bus.data_i;
          key_d   = bus.key_i;
          acc_d   = '0;
          dummy_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      StAcc: begin
        // Exactly one accumulator toggles per slot, whatever the valid bit says.
        if (slot_valid) acc_d = acc_q ^ rot;
        else            dummy_d = dummy_q ^ rot;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntWidth'(pW - 1)) begin
          state_d = StIdle;
          data_d  = acc_d;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      op_q    <= '0;
      key_q   <= '0;
      acc_q   <= '0;
      dummy_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      acc_q   <= acc_d;
      dummy_q <= dummy_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.busy_o  = busy_q;
  assign bus.ready_o = ready_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_sparse_rot_mult_core.sv
// Self-checking bench for sparse_rot_mult_core against a coefficient-level
// polynomial product model.
module tb_sparse_rot_mult_core;

  localparam int N = 128;
  localparam int W = 16;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  sparse_rot_mult_core_if #(.pN(128), .pKEY_WIDTH(128)) bus ();

  sparse_rot_mult_core #(
    .pN         (128),
    .pIDX_W     (7),
    .pW         (16),
    .pKEY_WIDTH (128)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product of the dense polynomial d and sum of x^pos over valid slots, mod x^N - 1.
  function automatic logic [127:0] ref_mult(logic [127:0] key, logic [127:0] d);
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < W; k++) begin
      logic [7:0] slot;
      int         pos;
      slot = key[8*k +: 8];
      pos  = int'(slot[6:0]);
      if (slot[7]) begin
        for (int i = 0; i < N; i++) res[i] = res[i] ^ d[(i - pos + N) % N];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load edge is cycle 0; returns with inputs released 1 ns after that edge.
  task automatic start_run(input logic [127:0] key, input logic [127:0] d);
    @(negedge clk);
    bus.load_i = 1'b1;
    bus.key_i  = key;
    bus.data_i = d;
    @(posedge clk);
    #1 bus.load_i = 1'b0;
  endtask

  // Watches cycles 1..W+3 after a load edge.
  task automatic observe_run(output int done_cyc, output int done_cnt, output bit shape_ok,
                             output logic [127:0] first_data);
    done_cyc   = -1;
    done_cnt   = 0;
    shape_ok   = 1'b1;
    first_data = '0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 1) first_data = bus.data_o;
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.busy_o !== 1'(c <= W)) shape_ok = 1'b0;
      if (bus.ready_o !== 1'(c > W)) shape_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    bus.load_i = 1'b0;
    bus.key_i  = '0;
    bus.data_i = '0;
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      checks += 4;
      if (bus.data_o !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.data_o); end
      if (bus.busy_o !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
      if (bus.done_o !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", bus.done_o); end
      if (bus.ready_o !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready_o); end
      resetn = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_run(input string name, input logic [127:0] key, input logic [127:0] d);
    int dc, dn; bit ok; logic [127:0] fd, exp;
    exp = ref_mult(key, d);
    start_run(key, d);
    observe_run(dc, dn, ok, fd);
    checks += 4;
    if (dc !== W + 1) begin errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, dc, W + 1); end
    if (dn !== 1)     begin errors++; $display("FAIL %s done_pulses got %0d exp 1", name, dn); end
    if (!ok)          begin errors++; $display("FAIL %s busy_ready_shape got bad exp busy 1..%0d", name, W); end
    if (bus.data_o !== exp) begin
      errors++; $display("FAIL %s data got %h exp %h", name, bus.data_o, exp);
    end
  endtask

  task automatic test_directed();
    check_run("identity", 128'h80, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    check_run("wrap", 128'h81, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
    checks++;
    if (bus.data_o !== 128'h3) begin errors++; $display("FAIL wrap_const got %h exp 3", bus.data_o); end
    check_run("sum", 128'h8280, 128'h1);
    checks++;
    if (bus.data_o !== 128'h5) begin errors++; $display("FAIL sum_const got %h exp 5", bus.data_o); end
    check_run("cancel", 128'h8585, rand128());
    check_run("all_invalid", 128'h7f7f_7f7f_1234_5678_0102_0304_0506_0708, rand128());
    checks++;
    if (bus.data_o !== 128'h0) begin errors++; $display("FAIL all_invalid_const got %h exp 0", bus.data_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) check_run("random", rand128(), rand128());
  endtask

  task automatic test_ignored_load();
    logic [127:0] key, d, exp;
    int dc, dn;
    key = rand128();
    d   = rand128();
    exp = ref_mult(key, d);
    start_run(key, d);
    dc = -1; dn = 0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin dn++; if (dc < 0) dc = c; end
      bus.load_i = (c == 5);
      if (c == 5) begin bus.key_i = rand128(); bus.data_i = rand128(); end
    end
    checks += 3;
    if (dc !== W + 1) begin errors++; $display("FAIL ignored_load done_cycle got %0d exp %0d", dc, W + 1); end
    if (dn !== 1)     begin errors++; $display("FAIL ignored_load done_pulses got %0d exp 1", dn); end
    if (bus.data_o !== exp) begin errors++; $display("FAIL ignored_load data got %h exp %h", bus.data_o, exp); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, da, ea, kb, db, eb, fd;
    int dc, dn; bit ok, a_done;
    ka = rand128(); da = rand128(); ea = ref_mult(ka, da);
    kb = rand128(); db = rand128(); eb = ref_mult(kb, db);
    start_run(ka, da);
    a_done = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == W + 1) a_done = bus.done_o;
    end
    checks += 2;
    if (a_done !== 1'b1)  begin errors++; $display("FAIL b2b_first_done got %b exp 1", a_done); end
    if (bus.data_o !== ea) begin errors++; $display("FAIL b2b_first_data got %h exp %h", bus.data_o, ea); end
    bus.load_i = 1'b1; bus.key_i = kb; bus.data_i = db;
    @(posedge clk);
    #1 bus.load_i = 1'b0;
    observe_run(dc, dn, ok, fd);
    checks += 5;
    if (dc !== W + 1) begin errors++; $display("FAIL b2b_done_cycle got %0d exp %0d", dc, W + 1); end
    if (dn !== 1)     begin errors++; $display("FAIL b2b_done_pulses got %0d exp 1", dn); end
    if (!ok)          begin errors++; $display("FAIL b2b_busy_shape got bad exp busy 1..%0d", W); end
    if (fd !== ea)    begin errors++; $display("FAIL b2b_hold got %h exp %h", fd, ea); end
    if (bus.data_o !== eb) begin errors++; $display("FAIL b2b_second_data got %h exp %h", bus.data_o, eb); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] key, d, fd;
    int dn, dc; bit ok;
    key = rand128(); d = rand128();
    start_run(key, d);
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks += 4;
    if (bus.data_o !== 128'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", bus.data_o); end
    if (bus.busy_o !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy_o); end
    if (bus.done_o !== 1'b0)   begin errors++; $display("FAIL midrst_done got %b exp 0", bus.done_o); end
    if (bus.ready_o !== 1'b1)  begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.ready_o); end
    dn = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) dn++;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", dn); end
    // Release reset with load already high: the first edge starts the run.
    key = rand128(); d = rand128();
    bus.load_i = 1'b1; bus.key_i = key; bus.data_i = d;
    resetn = 1'b1;
    @(posedge clk);
    #1 bus.load_i = 1'b0;
    observe_run(dc, dn, ok, fd);
    checks += 3;
    if (dc !== W + 1) begin errors++; $display("FAIL post_rst_done_cycle got %0d exp %0d", dc, W + 1); end
    if (!ok)          begin errors++; $display("FAIL post_rst_busy_shape got bad exp busy 1..%0d", W); end
    if (bus.data_o !== ref_mult(key, d)) begin
      errors++; $display("FAIL post_rst_data got %h exp %h", bus.data_o, ref_mult(key, d));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignored_load();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
